// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time trial sequencer.
// Runs idle -> random wait -> stimulus -> result/error, timing the player's
// response in milliseconds for the 4-digit seven-segment display driver.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | after reset, waiting for the first press
// S_WAIT | random pre-stimulus wait; a press here is an early press
// S_GO   | stimulus LED on, reaction time counting
// S_SHOW | result frozen on the display
// S_ERR  | early press, error pattern shown
module reaction_ctrl #(
  parameter int TICKS_PER_MS = 10000,
  parameter int MIN_WAIT_MS  = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  output logic        led,
  output logic [13:0] value,
  output logic        show_error,
  output logic        busy
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]   MAX_V     = 14'(MAX_MS);
  localparam logic [13:0]   MIN_V     = 14'(MIN_WAIT_MS);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_SHOW = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          s1, s2, prev;
  logic          press, tick;
  logic [15:0]   lfsr;
  logic [PW-1:0] prescaler, prescaler_nxt;
  logic [13:0]   ms_cnt, ms_cnt_nxt;
  logic [13:0]   wait_ms, wait_ms_nxt;
  logic [13:0]   rt_cnt, rt_cnt_nxt;
  logic [13:0]   value_nxt;

  assign press = s2 & ~prev;
  assign tick  = (prescaler == TICK_LAST);

  // Button synchronizer/edge detect and free-running Galois LFSR.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      lfsr <= LFSR_SEED;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      prescaler  <= '0;
      ms_cnt     <= '0;
      wait_ms    <= '0;
      rt_cnt     <= '0;
      value      <= '0;
      led        <= 1'b0;
      show_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      prescaler  <= prescaler_nxt;
      ms_cnt     <= ms_cnt_nxt;
      wait_ms    <= wait_ms_nxt;
      rt_cnt     <= rt_cnt_nxt;
      value      <= value_nxt;
      led        <= (state_nxt == S_GO);
      show_error <= (state_nxt == S_ERR);
      busy       <= (state_nxt == S_WAIT) || (state_nxt == S_GO);
    end
  end

  // Next-state and datapath decode; a press always beats a same-cycle tick.
  always_comb begin
    state_nxt     = state;
    prescaler_nxt = tick ? '0 : prescaler + 1'b1;
    ms_cnt_nxt    = ms_cnt;
    wait_ms_nxt   = wait_ms;
    rt_cnt_nxt    = rt_cnt;
    value_nxt     = value;
    case (state)
      S_IDLE, S_SHOW, S_ERR: begin
        if (press) begin
          state_nxt     = S_WAIT;
          wait_ms_nxt   = MIN_V + 14'(lfsr[RAND_BITS-1:0]);
          ms_cnt_nxt    = '0;
          prescaler_nxt = '0;
        end
      end
      S_WAIT: begin
        if (press) begin
          state_nxt = S_ERR;
        end else if (tick) begin
          if (ms_cnt + 14'd1 == wait_ms) begin
            state_nxt     = S_GO;
            rt_cnt_nxt    = '0;
            value_nxt     = '0;
            prescaler_nxt = '0;
          end else begin
            ms_cnt_nxt = ms_cnt + 14'd1;
          end
        end
      end
      S_GO: begin
        if (press) begin
          state_nxt = S_SHOW;
          value_nxt = rt_cnt;
        end else if (tick) begin
          if (rt_cnt + 14'd1 == MAX_V) begin
            state_nxt = S_SHOW;
            value_nxt = MAX_V;
          end else begin
            rt_cnt_nxt = rt_cnt + 14'd1;
            value_nxt  = rt_cnt + 14'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_ERR) value_nxt = '0;
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a small cycle-accurate LFSR model.
module tb_reaction_ctrl;

  localparam int T  = 4;
  localparam int MN = 3;
  localparam int RB = 2;
  localparam int MX = 20;

  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_GO   = 2;
  localparam int ST_SHOW = 3;
  localparam int ST_ERR  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn = 1'b0;
  logic        led;
  logic [13:0] value;
  logic        show_error;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_prev = 16'hACE1;

  reaction_ctrl #(
    .TICKS_PER_MS(T),
    .MIN_WAIT_MS (MN),
    .RAND_BITS   (RB),
    .MAX_MS      (MX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .led       (led),
    .value     (value),
    .show_error(show_error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value the DUT sampled at the last edge.
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single button pulse; returns just after the edge that acts on it.
  task automatic pulse();
    btn = 1'b1;
    step();
    btn = 1'b0;
    step(2);
  endtask

  task automatic wait_led(output int n);
    n = 0;
    while (!led && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int l,
                            input int v, input int e, input int b);
    check({tag, ".state"}, int'(dut.state), st);
    check({tag, ".led"}, int'(led), l);
    check({tag, ".value"}, int'(value), v);
    check({tag, ".show_error"}, int'(show_error), e);
    check({tag, ".busy"}, int'(busy), b);
  endtask

  int w, n;

  initial begin
    // Reset with button chatter.
    reset = 1'b1;
    btn = 1'b1; step();
    btn = 1'b0; step();
    btn = 1'b1; step();
    btn = 1'b0;
    check("rst_lfsr", int'(dut.lfsr), 16'hACE1);
    check_outs("rst", ST_IDLE, 0, 0, 0, 0);
    reset = 1'b0;
    step(6);
    check_outs("idle_hold", ST_IDLE, 0, 0, 0, 0);
    check("lfsr_run", int'(dut.lfsr), int'(m_lfsr));

    // Normal trial.
    pulse();
    w = MN + int'(m_prev[RB-1:0]);
    check_outs("wait1", ST_WAIT, 0, 0, 0, 1);
    wait_led(n);
    check("onset1", n, w * T);
    check_outs("go1", ST_GO, 1, 0, 0, 1);
    step(12);
    check("go1_live", int'(value), 3);
    step(14);
    pulse();
    check_outs("show1", ST_SHOW, 0, 7, 0, 0);

    // Early press then recovery.
    pulse();
    check_outs("wait2", ST_WAIT, 0, 7, 0, 1);
    step(2);
    pulse();
    check_outs("err1", ST_ERR, 0, 0, 1, 0);
    pulse();
    w = MN + int'(m_prev[RB-1:0]);
    check_outs("wait3", ST_WAIT, 0, 0, 0, 1);

    // Timeout.
    wait_led(n);
    check("onset3", n, w * T);
    step(79);
    check_outs("go3_end", ST_GO, 1, 19, 0, 1);
    step();
    check_outs("timeout", ST_SHOW, 0, MX, 0, 0);

    // Held button through expiry, then press on the MAX_MS tick.
    btn = 1'b1;
    step(3);
    w = MN + int'(m_prev[RB-1:0]);
    check_outs("wait4", ST_WAIT, 0, MX, 0, 1);
    wait_led(n);
    check("onset4_held", n, w * T);
    check_outs("go4_held", ST_GO, 1, 0, 0, 1);
    btn = 1'b0;
    step(77);
    pulse();
    check_outs("max_press", ST_SHOW, 0, 19, 0, 0);

    // Press landing on the expiry edge.
    pulse();
    w = MN + int'(m_prev[RB-1:0]);
    step(w * T - 3);
    pulse();
    check_outs("expiry_press", ST_ERR, 0, 0, 1, 0);

    // Reset mid-GO.
    pulse();
    w = MN + int'(m_prev[RB-1:0]);
    wait_led(n);
    check("onset6", n, w * T);
    step(12);
    check_outs("go6", ST_GO, 1, 3, 0, 1);
    reset = 1'b1;
    step();
    check_outs("rst_mid", ST_IDLE, 0, 0, 0, 0);
    check("rst_mid_lfsr", int'(dut.lfsr), 16'hACE1);
    reset = 1'b0;
    step(3);
    check_outs("post_rst", ST_IDLE, 0, 0, 0, 0);
    check("lfsr_end", int'(dut.lfsr), int'(m_lfsr));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
